// File: rtl/fmesh_xy_route_unit_pkg.sv
// Shared definitions for the fmesh XY routing lookup: port numbering,
// width helper and the decoded endpoint record.
package fmesh_xy_route_unit_pkg;

  localparam int LOCAL = 0;
  localparam int EAST  = 1;
  localparam int NORTH = 2;
  localparam int WEST  = 3;
  localparam int SOUTH = 4;
  localparam int MAX_P = 5;

  // Wide enough for any practical mesh dimension; users slice to their widths.
  localparam int FIELD_W = 8;

  typedef struct packed {
    logic [FIELD_W-1:0] ep;
    logic [FIELD_W-1:0] ey;
    logic [FIELD_W-1:0] ex;
  } endp_t;

  // Ceiling log2, never below 1 so a single-router dimension still has a bit.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fmesh_endp_field_decode.sv
// Combinational split of an endpoint address {ep, y, x} plus legality check.
// Edge endpoints are only legal on the matching mesh boundary, and only in FMESH.
module fmesh_endp_field_decode
  import fmesh_xy_route_unit_pkg::*;
#(
  parameter string TOPOLOGY = "FMESH",
  parameter int    T1       = 4,
  parameter int    T2       = 4,
  parameter int    Pw       = 3,
  parameter int    Xw       = log2(T1),
  parameter int    Yw       = log2(T2),
  parameter int    EAw      = Pw + Yw + Xw
) (
  input  logic [EAw-1:0] addr,
  output endp_t          fields,
  output logic           legal
);

  localparam bit IS_MESH = (TOPOLOGY == "MESH");

  logic [Xw-1:0] x;
  logic [Yw-1:0] y;
  logic [Pw-1:0] p;

  assign x = addr[Xw-1:0];
  assign y = addr[Yw+Xw-1:Xw];
  assign p = addr[EAw-1:Yw+Xw];

  assign fields.ex = FIELD_W'(x);
  assign fields.ey = FIELD_W'(y);
  assign fields.ep = FIELD_W'(p);

  always_comb begin
    legal = (p == Pw'(LOCAL));
    if (!IS_MESH) begin
      if (p == Pw'(EAST)  && x == Xw'(T1 - 1)) legal = 1'b1;
      if (p == Pw'(WEST)  && x == Xw'(0))      legal = 1'b1;
      if (p == Pw'(NORTH) && y == Yw'(0))      legal = 1'b1;
      if (p == Pw'(SOUTH) && y == Yw'(T2 - 1)) legal = 1'b1;
    end
  end

endmodule

// File: rtl/fmesh_xy_route_unit.sv
// Registered XY route lookup: one cycle from valid_in to valid_out, no stall.
// Result registers load only on valid_in; valid_out simply follows valid_in.
module fmesh_xy_route_unit
  import fmesh_xy_route_unit_pkg::*;
#(
  parameter string TOPOLOGY = "FMESH",
  parameter int    T1       = 4,
  parameter int    T2       = 4,
  parameter int    Pw       = 3,
  parameter int    Xw       = log2(T1),
  parameter int    Yw       = log2(T2),
  parameter int    EAw      = Pw + Yw + Xw,
  parameter int    RAw      = Yw + Xw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [RAw-1:0]   current_r_addr,
  input  logic [EAw-1:0]   dest_e_addr,
  output logic             valid_out,
  output logic [Pw-1:0]    destport,
  output logic [MAX_P-1:0] destport_one_hot,
  output logic [Xw-1:0]    ex,
  output logic [Yw-1:0]    ey,
  output logic [Pw-1:0]    ep,
  output logic             addr_err
);

  endp_t dec;
  logic  legal;

  fmesh_endp_field_decode #(
    .TOPOLOGY (TOPOLOGY),
    .T1       (T1),
    .T2       (T2),
    .Pw       (Pw),
    .Xw       (Xw),
    .Yw       (Yw),
    .EAw      (EAw)
  ) u_decode (
    .addr   (dest_e_addr),
    .fields (dec),
    .legal  (legal)
  );

  logic [Xw-1:0] cx, dx;
  logic [Yw-1:0] cy, dy;
  logic [Pw-1:0] dp;

  assign cx = current_r_addr[Xw-1:0];
  assign cy = current_r_addr[RAw-1:Xw];
  assign dx = dec.ex[Xw-1:0];
  assign dy = dec.ey[Yw-1:0];
  assign dp = dec.ep[Pw-1:0];

  // Upper record bits are zero padding beyond this instance's widths.
  logic unused_fields;
  assign unused_fields = ^{dec.ep, dec.ey, dec.ex};

  logic [Pw-1:0]    port_nxt;
  logic [MAX_P-1:0] one_hot_nxt;

  always_comb begin
    if (dx > cx)      port_nxt = Pw'(EAST);
    else if (dx < cx) port_nxt = Pw'(WEST);
    else if (dy > cy) port_nxt = Pw'(SOUTH);
    else if (dy < cy) port_nxt = Pw'(NORTH);
    else              port_nxt = dp;

    one_hot_nxt = '0;
    if (legal) one_hot_nxt = MAX_P'(1) << port_nxt;
    else       port_nxt    = Pw'(LOCAL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out        <= 1'b0;
      destport         <= '0;
      destport_one_hot <= '0;
      ex               <= '0;
      ey               <= '0;
      ep               <= '0;
      addr_err         <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        destport         <= port_nxt;
        destport_one_hot <= one_hot_nxt;
        ex               <= dx;
        ey               <= dy;
        ep               <= dp;
        addr_err         <= ~legal;
      end
    end
  end

endmodule

// File: tb/tb_fmesh_xy_route_unit.sv
// Bench for fmesh_xy_route_unit: directed vector table, hand-written reset and
// streaming sequences, then randomized traffic against a reference model.
module tb_fmesh_xy_route_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_in = 1'b0;
  logic [3:0] current_r_addr = '0;
  logic [6:0] dest_e_addr = '0;

  logic       f_valid, m_valid, f_err, m_err;
  logic [2:0] f_port, m_port, f_ep, m_ep;
  logic [4:0] f_oh, m_oh;
  logic [1:0] f_ex, m_ex, f_ey, m_ey;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fmesh_xy_route_unit #(.TOPOLOGY("FMESH"), .T1(4), .T2(4), .Pw(3)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .current_r_addr(current_r_addr), .dest_e_addr(dest_e_addr),
    .valid_out(f_valid), .destport(f_port), .destport_one_hot(f_oh),
    .ex(f_ex), .ey(f_ey), .ep(f_ep), .addr_err(f_err));

  fmesh_xy_route_unit #(.TOPOLOGY("MESH"), .T1(4), .T2(4), .Pw(3)) dut_m (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .current_r_addr(current_r_addr), .dest_e_addr(dest_e_addr),
    .valid_out(m_valid), .destport(m_port), .destport_one_hot(m_oh),
    .ex(m_ex), .ey(m_ey), .ep(m_ep), .addr_err(m_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: routing rules evaluated on plain integers.
  function automatic void model(input int cx, input int cy, input int x, input int y,
                                input int p, input bit mesh,
                                output int port, output int oh, output int err);
    bit ok;
    ok = (p == 0);
    if (!mesh) ok = ok || (p == 1 && x == 3) || (p == 3 && x == 0) ||
                         (p == 2 && y == 0) || (p == 4 && y == 3);
    if (x > cx)      port = 1;
    else if (x < cx) port = 3;
    else if (y > cy) port = 4;
    else if (y < cy) port = 2;
    else             port = p;
    if (ok) begin err = 0; oh = 1 << port; end
    else    begin err = 1; oh = 0; port = 0; end
  endfunction

  task automatic drive(input int cx, input int cy, input int x, input int y, input int p);
    current_r_addr = {2'(cy), 2'(cx)};
    dest_e_addr    = {3'(p), 2'(y), 2'(x)};
  endtask

  typedef struct {
    int cx, cy, x, y, p;
    bit mesh;
    int port, oh, err;
  } vec_t;

  vec_t vecs[12];

  int e_port[2], e_oh[2], e_err[2], e_x, e_y, e_p;

  task automatic check_both(input string tag, input logic vexp);
    chk({tag, " f_valid"}, f_valid, vexp);
    chk({tag, " f_port"},  f_port,  e_port[0]);
    chk({tag, " f_oh"},    f_oh,    e_oh[0]);
    chk({tag, " f_err"},   f_err,   e_err[0]);
    chk({tag, " f_ex"},    f_ex,    e_x);
    chk({tag, " f_ey"},    f_ey,    e_y);
    chk({tag, " f_ep"},    f_ep,    e_p);
    chk({tag, " m_valid"}, m_valid, vexp);
    chk({tag, " m_port"},  m_port,  e_port[1]);
    chk({tag, " m_oh"},    m_oh,    e_oh[1]);
    chk({tag, " m_err"},   m_err,   e_err[1]);
  endtask

  initial begin
    //            cx cy x  y  p  mesh port oh     err
    vecs[0]  = '{1, 1, 3, 1, 0, 0, 1, 5'b00010, 0};
    vecs[1]  = '{2, 2, 2, 0, 0, 0, 2, 5'b00100, 0};
    vecs[2]  = '{2, 2, 2, 3, 0, 0, 4, 5'b10000, 0};
    vecs[3]  = '{0, 0, 0, 0, 3, 0, 3, 5'b01000, 0};
    vecs[4]  = '{0, 0, 0, 0, 3, 1, 0, 5'b00000, 1};
    vecs[5]  = '{1, 1, 1, 1, 1, 0, 0, 5'b00000, 1};
    vecs[6]  = '{3, 3, 3, 3, 0, 0, 0, 5'b00001, 0};
    vecs[7]  = '{3, 0, 3, 0, 2, 0, 2, 5'b00100, 0};
    vecs[8]  = '{2, 2, 2, 2, 5, 0, 0, 5'b00000, 1};
    vecs[9]  = '{0, 3, 0, 3, 4, 0, 4, 5'b10000, 0};
    vecs[10] = '{3, 1, 0, 2, 0, 0, 3, 5'b01000, 0};
    vecs[11] = '{0, 1, 3, 3, 1, 0, 1, 5'b00010, 0};

    // Reset state while held low.
    #2;
    chk("rst valid", f_valid, 0);
    chk("rst port", f_port, 0);
    chk("rst oh", f_oh, 0);
    chk("rst err", f_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].cx, vecs[i].cy, vecs[i].x, vecs[i].y, vecs[i].p);
      valid_in = 1'b1;
      @(posedge clk); #1;
      if (vecs[i].mesh) begin
        chk($sformatf("vec%0d valid", i), m_valid, 1);
        chk($sformatf("vec%0d port", i),  m_port, vecs[i].port);
        chk($sformatf("vec%0d oh", i),    m_oh, vecs[i].oh);
        chk($sformatf("vec%0d err", i),   m_err, vecs[i].err);
      end else begin
        chk($sformatf("vec%0d valid", i), f_valid, 1);
        chk($sformatf("vec%0d port", i),  f_port, vecs[i].port);
        chk($sformatf("vec%0d oh", i),    f_oh, vecs[i].oh);
        chk($sformatf("vec%0d err", i),   f_err, vecs[i].err);
        chk($sformatf("vec%0d ex", i),    f_ex, vecs[i].x);
        chk($sformatf("vec%0d ey", i),    f_ey, vecs[i].y);
        chk($sformatf("vec%0d ep", i),    f_ep, vecs[i].p);
      end
    end

    // Hold: valid_in low keeps the last result (vec11) but drops valid_out.
    @(negedge clk);
    valid_in = 1'b0;
    drive(2, 2, 0, 0, 0);
    @(posedge clk); #1;
    chk("hold valid", f_valid, 0);
    chk("hold port", f_port, 1);
    chk("hold oh", f_oh, 5'b00010);
    chk("hold ex", f_ex, 3);

    // Back-to-back requests: no gap in valid_out.
    @(negedge clk);
    drive(3, 3, 3, 3, 0);
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b%0d valid", i), f_valid, 1);
      chk($sformatf("b2b%0d oh", i), f_oh, 5'b00001);
    end

    // Asynchronous reset mid-cycle with a request in flight.
    @(negedge clk);
    drive(1, 1, 3, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst valid", f_valid, 0);
    chk("arst port", f_port, 0);
    chk("arst oh", f_oh, 0);
    chk("arst fields", {f_ex, f_ey, f_ep}, 0);
    chk("arst err", f_err, 0);
    @(negedge clk);
    valid_in = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post-rel valid", f_valid, 0);
    chk("post-rel port", f_port, 0);

    // Randomized traffic against the model, including idle cycles.
    e_port = '{0, 0}; e_oh = '{0, 0}; e_err = '{0, 0};
    e_x = 0; e_y = 0; e_p = 0;
    for (int i = 0; i < 300; i++) begin
      int cx, cy, x, y, p;
      logic v;
      @(negedge clk);
      cx = $urandom_range(3); cy = $urandom_range(3);
      x = $urandom_range(3);  y = $urandom_range(3);
      p = $urandom_range(7);
      v = ($urandom_range(9) < 7);
      drive(cx, cy, x, y, p);
      valid_in = v;
      @(posedge clk); #1;
      if (v) begin
        model(cx, cy, x, y, p, 1'b0, e_port[0], e_oh[0], e_err[0]);
        model(cx, cy, x, y, p, 1'b1, e_port[1], e_oh[1], e_err[1]);
        e_x = x; e_y = y; e_p = p;
      end
      check_both($sformatf("rnd%0d", i), v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fmesh_xy_route_unit.md
# fmesh_xy_route_unit

Registered XY routing lookup for a 2D mesh or fmesh NoC. It decodes a destination endpoint address, compares it with the current router address, and produces the output port as both an encoded value and a one-hot value. It sits in the network-interface and router lookahead path, between the flit-header builder and the output-port allocator. It also exposes the decoded destination fields so the egress wrapper can rebuild foreign-protocol headers.

## Interface
- TOPOLOGY, "FMESH": "FMESH" (edge endpoints allowed) or "MESH" (local endpoints only).
- T1, 4: routers in X (NX).
- T2, 4: routers in Y (NY).
- Xw / Yw, log2(T1) / log2(T2): derived widths.
- Pw, 3: port-field width (MAX_P=5).
- EAw, Pw+Yw+Xw: endpoint address width. Layout is {ep, y, x}.
- RAw, Yw+Xw: router address width. Layout is {y, x}.

Ports:
- clk  in  1  clock.
- reset  in  1  reset. One clock; reset is asynchronous and active-low.
- valid_in  in  1  a lookup request is present this cycle.
- current_r_addr  in  RAw  address of the router that owns the lookup.
- dest_e_addr  in  EAw  destination endpoint address.
- valid_out  out  1  registered result is valid.
- destport  out  Pw  registered encoded output port.
- destport_one_hot  out  5  registered one-hot output port.
- ex / ey / ep  out  Xw / Yw / Pw  registered decoded destination fields.
- addr_err  out  1  registered flag: the destination address is illegal.

## Operation
- Port numbering: LOCAL=0, EAST=1, NORTH=2, WEST=3, SOUTH=4.
- Directions: EAST is x+1, WEST is x-1, NORTH is y-1, SOUTH is y+1.
- Decode: ex=dest[Xw-1:0], ey=dest[Yw+Xw-1:Xw], ep=dest[EAw-1:Yw+Xw].
- Address legality:
  - legal when ep==LOCAL;
  - legal when ep==EAST and ex==NX-1;
  - legal when ep==WEST and ex==0;
  - legal when ep==NORTH and ey==0;
  - legal when ep==SOUTH and ey==NY-1;
  - every other case is illegal, including ep>4;
  - in MESH mode only ep==LOCAL is legal.
- XY routing, with cx/cy taken from current_r_addr:
  - if ex>cx, route EAST; if ex<cx, route WEST;
  - else if ey>cy, route SOUTH; if ey<cy, route NORTH;
  - else route to port ep, which ejects to the local or edge endpoint.
- Comparisons are unsigned. There is no wrap-around, because mesh links do not wrap.
- destport_one_hot = 1<<destport.
- On an illegal address: addr_err=1, destport=LOCAL, destport_one_hot=0.
- The registers capture new values only when valid_in=1.
  - valid_out follows valid_in every cycle.
  - The other outputs hold their last value while valid_in=0.

## Timing
- Latency is exactly 1 cycle from valid_in to valid_out.
- Back-to-back requests every cycle are supported. There is no stall and no backpressure.
- Reset is asserted asynchronously. While reset is low:
  - valid_out=0;
  - destport=0;
  - destport_one_hot=0;
  - ex=0, ey=0, ep=0;
  - addr_err=0.
- Release is synchronous to clk. The first capture happens at the first rising edge after release.
- Reset asserted mid-operation drops an in-flight result immediately and with no partial output.
- The input fields are combinational into the registers. The entire decode and route must fit in one cycle.

## Structure
- Shared package holds:
  - the port constants LOCAL/EAST/NORTH/WEST/SOUTH and MAX_P;
  - the log2 function;
  - a typedef for the decoded endpoint struct {ep, ey, ex}.
- One sub-module, fmesh_endp_field_decode, contains the pure combinational field split plus the legality check. It is reused by the egress wrapper.
- The top level holds the XY compare and the output registers.

## Test plan
All scenarios use NX=NY=4 and EAw=7.
- Current (1,1), dest x=3,y=1,ep=0 -> next cycle valid_out=1, destport=1, one_hot=5'b00010.
- Current (2,2), dest x=2,y=0,ep=0 -> destport=2 (NORTH), one_hot=5'b00100; then dest y=3 -> destport=4, one_hot=5'b10000.
- Current (0,0), dest x=0,y=0,ep=WEST -> destport=3, one_hot=5'b01000, addr_err=0. The same request in MESH mode -> addr_err=1, one_hot=0.
- Current (1,1), dest x=1,y=1,ep=EAST -> addr_err=1, destport=0, one_hot=0, valid_out=1. The request is illegal because ex≠3.
- Current (3,3), dest x=3,y=3,ep=0 -> destport=0, one_hot=5'b00001. Repeat the request every cycle for 4 cycles -> valid_out stays high with no gap.
- Drive a request, then pull reset low mid-cycle before the edge -> all outputs are 0 immediately. After release with valid_in=0 -> valid_out stays 0.
